// File: rtl/gpu_net_hub.sv
// GPU group network hub: per-input FIFOs, dest_id routing, round-robin
// output arbitration and saturating drop counter for out-of-group flits.
module gpu_net_hub #(
    parameter int NUM_PORTS  = 4,
    parameter int BASE_ID    = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [NUM_PORTS*16-1:0] in_data,
    input  logic [NUM_PORTS-1:0]    in_valid,
    output logic [NUM_PORTS-1:0]    in_ready,
    output logic [NUM_PORTS*16-1:0] out_data,
    output logic [NUM_PORTS-1:0]    out_valid,
    input  logic [NUM_PORTS-1:0]    out_ready,
    output logic [15:0]             drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [6:0] ID_LO = 7'(BASE_ID);
    localparam logic [6:0] ID_HI = 7'(BASE_ID + NUM_PORTS - 1);

    logic [15:0]   mem_q      [NUM_PORTS][FIFO_DEPTH];
    logic [15:0]   mem_d      [NUM_PORTS][FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q   [NUM_PORTS];
    logic [AW:0]   wr_ptr_d   [NUM_PORTS];
    logic [AW:0]   rd_ptr_q   [NUM_PORTS];
    logic [AW:0]   rd_ptr_d   [NUM_PORTS];
    logic [15:0]   out_data_q [NUM_PORTS];
    logic [15:0]   out_data_d [NUM_PORTS];
    logic [PW-1:0] rr_ptr_q   [NUM_PORTS];
    logic [PW-1:0] rr_ptr_d   [NUM_PORTS];
    logic [NUM_PORTS-1:0] out_valid_q;
    logic [NUM_PORTS-1:0] out_valid_d;
    logic [15:0]   drop_count_q;
    logic [15:0]   drop_count_d;

    logic [15:0]          head [NUM_PORTS];
    logic [PW-1:0]        tgt  [NUM_PORTS];
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] hit;
    logic [NUM_PORTS-1:0] drop;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;

    // FIFO status and head decode
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            logic [6:0] dest7;
            full[p]  = (wr_ptr_q[p][AW] != rd_ptr_q[p][AW]) &&
                       (wr_ptr_q[p][AW-1:0] == rd_ptr_q[p][AW-1:0]);
            empty[p] = (wr_ptr_q[p] == rd_ptr_q[p]);
            head[p]  = mem_q[p][rd_ptr_q[p][AW-1:0]];
            dest7    = {1'b0, head[p][15:10]};
            hit[p]   = !empty[p] && (dest7 >= ID_LO) && (dest7 <= ID_HI);
            drop[p]  = !empty[p] && !hit[p];
            tgt[p]   = PW'(dest7 - ID_LO);
            push[p]  = in_valid[p] && !full[p];
        end
    end

    // Output slots and round-robin grant
    always_comb begin
        pop         = drop;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rr_ptr_d    = rr_ptr_q;
        for (int q = 0; q < NUM_PORTS; q++) begin
            logic          found;
            logic [PW-1:0] gnt;
            logic [PW-1:0] cand;
            int            c;
            found = 1'b0;
            gnt   = '0;
            cand  = '0;
            c     = 0;
            if (!out_valid_q[q] || out_ready[q]) begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    c = int'(rr_ptr_q[q]) + i;
                    if (c >= NUM_PORTS) c = c - NUM_PORTS;
                    cand = PW'(c);
                    if (!found && hit[cand] && (tgt[cand] == PW'(q))) begin
                        found = 1'b1;
                        gnt   = cand;
                    end
                end
                if (found) begin
                    out_data_d[q]  = head[gnt];
                    out_valid_d[q] = 1'b1;
                    pop[gnt]       = 1'b1;
                    rr_ptr_d[q]    = PW'((int'(gnt) + 1) % NUM_PORTS);
                end else begin
                    out_valid_d[q] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        mem_d = mem_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            wr_ptr_d[p] = wr_ptr_q[p] + (AW+1)'(push[p]);
            rd_ptr_d[p] = rd_ptr_q[p] + (AW+1)'(pop[p]);
            if (push[p])
                mem_d[p][wr_ptr_q[p][AW-1:0]] = in_data[16*p +: 16];
        end
    end

    always_comb begin
        logic [16:0] sum;
        sum = {1'b0, drop_count_q};
        for (int p = 0; p < NUM_PORTS; p++)
            sum = sum + 17'(drop[p]);
        drop_count_d = sum[16] ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int e = 0; e < FIFO_DEPTH; e++)
                    mem_q[p][e] <= '0;
                wr_ptr_q[p]   <= '0;
                rd_ptr_q[p]   <= '0;
                out_data_q[p] <= '0;
                rr_ptr_q[p]   <= '0;
            end
            out_valid_q  <= '0;
            drop_count_q <= '0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_data_q   <= out_data_d;
            rr_ptr_q     <= rr_ptr_d;
            out_valid_q  <= out_valid_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++)
            out_data[16*p +: 16] = out_data_q[p];
    end

    assign in_ready   = ~full;
    assign out_valid  = out_valid_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_gpu_net_hub.sv
// Directed bench for gpu_net_hub: routing, contention, backpressure,
// drops with saturation, loopback and mid-operation reset.
module tb_gpu_net_hub;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [63:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] drop_count;

    int compared   = 0;
    int mismatched = 0;

    always #5 ACLK = ~ACLK;

    gpu_net_hub #(.NUM_PORTS(4), .BASE_ID(20), .FIFO_DEPTH(4)) dut (
        .ACLK(ACLK),
        .ARESETn(ARESETn),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .drop_count(drop_count)
    );

    function automatic logic [15:0] od(input int q);
        return out_data[16*q +: 16];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic burst(input string tag, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] c);
        in_data[15:0]  = a;
        in_data[47:32] = b;
        in_data[63:48] = c;
        in_valid = 4'b1101;
        tick;
        in_valid = 4'b0000;
        tick;
        chk({tag, "_v0"}, out_valid, 4'b0001);
        chk({tag, "_d0"}, od(0), a);
        tick;
        chk({tag, "_d1"}, od(0), b);
        tick;
        chk({tag, "_d2"}, od(0), c);
        tick;
        chk({tag, "_idle"}, out_valid, 4'b0000);
    endtask

    logic [15:0] bp  [6];
    logic [15:0] got [6];
    logic [15:0] mr  [4];
    int n_push;
    int n_got;
    int stale;

    initial begin
        bp = '{16'h5920, 16'h5921, 16'h5922, 16'h5923, 16'h5924, 16'h5925};
        mr = '{16'h5520, 16'h5521, 16'h5522, 16'h5523};
        ARESETn   = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = '0;
        #2;
        chk("rst_in_ready", in_ready, 4'b1111);
        chk("rst_out_valid", out_valid, 4'b0000);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_drop", drop_count, 16'h0);
        tick;
        tick;
        ARESETn = 1'b1;
        #1;
        chk("post_rst_ready", in_ready, 4'b1111);

        // single route port 0 -> dest 21
        out_ready = 4'b1111;
        in_data[15:0] = 16'h5523;
        in_valid = 4'b0001;
        tick;
        in_valid = 4'b0000;
        chk("route_lat", out_valid, 4'b0000);
        tick;
        chk("route_v", out_valid, 4'b0010);
        chk("route_d", od(1), 16'h5523);
        chk("route_drop", drop_count, 16'h0);
        tick;
        chk("route_idle", out_valid, 4'b0000);

        // contention on output 0, twice
        burst("rr1", 16'h5100, 16'h5102, 16'h5103);
        burst("rr2", 16'h5110, 16'h5112, 16'h5113);

        // backpressure on output 2
        out_ready = 4'b1011;
        n_push = 0;
        in_data[31:16] = bp[0];
        in_valid = 4'b0010;
        for (int c = 0; c < 8; c++) begin
            if (in_ready[1]) n_push++;
            tick;
            in_data[31:16] = bp[n_push];
        end
        chk("bp_pushed", n_push, 5);
        chk("bp_ready", in_ready, 4'b1101);
        chk("bp_v", out_valid, 4'b0100);
        chk("bp_d", od(2), 16'h5920);
        tick;
        chk("bp_hold", od(2), 16'h5920);
        chk("bp_hold_v", out_valid, 4'b0100);

        out_ready = 4'b1111;
        n_got = 0;
        for (int c = 0; c < 40 && n_got < 6; c++) begin
            if (out_valid[2]) begin
                got[n_got] = od(2);
                n_got++;
            end
            if (in_valid[1] && in_ready[1]) n_push++;
            tick;
            if (n_push < 6) in_data[31:16] = bp[n_push];
            else in_valid = 4'b0000;
        end
        chk("bp_got", n_got, 6);
        chk("bp_pushed_all", n_push, 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("bp_order%0d", i), got[i], bp[i]);
        tick;
        tick;
        chk("bp_no_dup", out_valid, 4'b0000);
        chk("bp_ready_end", in_ready, 4'b1111);

        // drop of dest 63 then valid flit
        in_data[63:48] = 16'hFD23;
        in_valid = 4'b1000;
        tick;
        in_data[63:48] = 16'h5123;
        tick;
        in_valid = 4'b0000;
        chk("drop_cnt", drop_count, 16'd1);
        chk("drop_nov", out_valid, 4'b0000);
        tick;
        chk("drop_v", out_valid, 4'b0001);
        chk("drop_d", od(0), 16'h5123);
        chk("drop_cnt2", drop_count, 16'd1);
        tick;
        chk("drop_idle", out_valid, 4'b0000);

        // saturation: four drops per cycle
        in_data = {4{16'hFD23}};
        in_valid = 4'b1111;
        repeat (100) tick;
        chk("sat_mid", drop_count, 16'd397);
        repeat (16284) tick;
        chk("sat_pre", drop_count, 16'hFFFD);
        tick;
        chk("sat_hit", drop_count, 16'hFFFF);
        in_valid = 4'b0000;
        repeat (3) tick;
        chk("sat_hold", drop_count, 16'hFFFF);
        chk("sat_nov", out_valid, 4'b0000);

        // loopback plus push/pop in same cycle on port 0
        in_data[15:0]  = 16'h5100;
        in_data[31:16] = 16'h5511;
        in_valid = 4'b0011;
        tick;
        in_data[15:0] = 16'h5101;
        in_valid = 4'b0001;
        tick;
        in_valid = 4'b0000;
        chk("lb_v", out_valid, 4'b0011);
        chk("lb_d1", od(1), 16'h5511);
        chk("lb_d0", od(0), 16'h5100);
        chk("lb_ready", in_ready, 4'b1111);
        tick;
        chk("lb_v2", out_valid, 4'b0001);
        chk("lb_d0b", od(0), 16'h5101);
        tick;
        chk("lb_idle", out_valid, 4'b0000);

        // reset with buffered flits and a held output
        out_ready = 4'b1101;
        in_valid = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            in_data[15:0] = mr[i];
            tick;
        end
        in_valid = 4'b0000;
        chk("mr_v", out_valid, 4'b0010);
        chk("mr_d", od(1), 16'h5520);
        ARESETn = 1'b0;
        #1;
        chk("mr_v0", out_valid, 4'b0000);
        chk("mr_d0", out_data, 64'h0);
        chk("mr_ready", in_ready, 4'b1111);
        chk("mr_drop", drop_count, 16'h0);
        tick;
        tick;
        ARESETn = 1'b1;
        out_ready = 4'b1111;
        stale = 0;
        repeat (10) begin
            tick;
            if (out_valid != 4'b0000) stale++;
        end
        chk("mr_stale", stale, 0);
        chk("mr_ready2", in_ready, 4'b1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/gpu_net_hub.md
Name: gpu_net_hub

Overview:
- Network-side endpoint for the 16-bit GPU network interface. Connects NUM_PORTS GPU nodes in a group.
- Each GPU sends flits of the form {dest_id[5:0], payload[9:0]}. The hub buffers each flit in a per-input FIFO and routes it by dest_id to the output port of the matching GPU.
- Outputs are arbitrated round-robin. Flits addressed to IDs outside the group are dropped and counted.

Parameters:
- NUM_PORTS, 4, number of attached GPU ports; port p serves GPU ID BASE_ID+p.
- BASE_ID, 20, GPU ID of port 0 (6-bit range).
- FIFO_DEPTH, 4, entries per input FIFO; power of 2, minimum 2.

Ports:
- ACLK  input  1  clock; all state updates on the rising edge.
- ARESETn  input  1  asynchronous active-low reset.
- in_data  input  NUM_PORTS*16  flit from each GPU's net_data_out; port p occupies bits [16p+15:16p].
- in_valid  input  NUM_PORTS  per-port flit valid, from GPU net_valid_out.
- in_ready  output  NUM_PORTS  per-port space available, to GPU net_ready_in.
- out_data  output  NUM_PORTS*16  flit to each GPU's net_data_in; same bit packing as in_data.
- out_valid  output  NUM_PORTS  per-port flit valid, to GPU net_valid_in.
- out_ready  input  NUM_PORTS  per-port GPU accept, from GPU net_ready_out.
- drop_count  output  16  number of flits discarded for an out-of-group dest_id; saturates at 16'hFFFF.

Behaviour:
- Reset (ARESETn low, asynchronous):
  - All FIFOs empty; out_valid=0; out_data=0; drop_count=0.
  - All round-robin pointers=0.
  - in_ready=1 on every port, both during and after reset.
  - A reset asserted mid-operation discards every buffered and in-flight flit. No partial transfer completes.
- Input side:
  - A push occurs when in_valid[p] && in_ready[p].
  - in_ready[p] = !full[p], driven combinationally from the FIFO count.
  - No push while full, even in a cycle where a pop happens.
- Routing (per FIFO head):
  - dest = head[15:10]; idx = dest - BASE_ID.
  - If BASE_ID <= dest <= BASE_ID+NUM_PORTS-1, the head requests output idx. Loopback (idx == own port) is legal.
  - Otherwise the head is invalid: it is popped on the next edge without arbitration and drop_count increments by 1 (saturating).
  - Multiple invalid heads in one cycle add their total count to drop_count, saturating.
- Output register, per output q:
  - The slot is free when !out_valid[q] or (out_valid[q] && out_ready[q]).
  - When free and at least one head requests q, the grant goes to the first requesting input at or after rr_ptr[q], searching cyclically.
  - On grant: out_data[q] loads that head, out_valid[q]=1, the input FIFO pops, and rr_ptr[q] = granted+1 mod NUM_PORTS.
  - When free with no request, out_valid[q] goes to 0 on the next edge.
  - Back-to-back delivery is allowed: a new flit loads in the same edge the previous one is accepted.
  - While out_valid[q] && !out_ready[q], out_data[q] and out_valid[q] hold stable.
- Each head has exactly one destination, so an input is popped by at most one output per cycle.
- Latency: a flit pushed on edge k into an empty FIFO, with its output free, gives out_valid high after edge k+1. Sustained throughput is 1 flit/cycle/output.
- FIFO pointers:
  - Read/write pointers are log2(FIFO_DEPTH)+1 bits; they wrap modulo 2*FIFO_DEPTH.
  - full = (MSBs differ and lower bits equal); empty = (pointers equal).
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps the count unchanged.
- The hub never modifies payload bits; out_data equals the input flit exactly.

Test Plan:
- Single route: reset, then port 0 sends 16'h5523 (dest 21, payload 0x123) for one cycle -> out_valid[1]=1 with out_data[1]=16'h5523 two edges after the push; no other out_valid; drop_count=0.
- Contention:
  - Ports 0, 2 and 3 each push a flit to dest 20 (16'h5123) in the same cycle, out_ready[0]=1 -> port 0 delivers three flits on consecutive cycles in order input 0, 2, 3.
  - A second burst of the same kind is then served starting from input 0 again, since rr_ptr[0]=0 after wrapping.
- Backpressure:
  - Hold out_ready[2]=0; port 1 pushes 6 flits 16'h5923 -> out_data[2] is stable, one flit sits in the output register and in_ready[1] drops to 0 once its FIFO holds 4.
  - Release out_ready[2] -> all 6 delivered in order with no loss or duplication.
- Drop: port 3 sends 16'hFD23 (dest 63) and then 16'h5123 -> drop_count=1 and only 16'h5123 appears on port 0. Drop counting saturates at 16'hFFFF under forced repetition.
- Loopback and simultaneity: port 1 sends to dest 21 while port 0 pushes to and pops from its FIFO in the same cycle -> loopback is delivered on out[1] and port 0's FIFO count is unchanged.
- Reset mid-operation: assert ARESETn low with 3 flits buffered and out_valid[1]=1 -> out_valid=0 and out_data=0 immediately; in_ready=4'b1111; after release no stale flit is ever emitted.
